// File: rtl/dmem_wr_arbiter_if.sv
// Producer/RAM-side bundle of the DMEM write arbiter.
interface dmem_wr_arbiter_if #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_ready;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_auto;
  logic [NUM_CH*ADDR_W-1:0] ch_base;
  logic [NUM_CH-1:0]        ch_load;
  logic                     hold;
  logic                     mem_wren;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_data;
  logic [CH_W-1:0]          mem_ch;
  logic [NUM_CH*LVL_W-1:0]  ch_level;
  logic                     idle;

  // Producers and the stall source drive the requests; they observe the RAM side.
  modport master (
    output ch_valid, ch_addr, ch_data, ch_auto, ch_base, ch_load, hold,
    input  ch_ready, mem_wren, mem_addr, mem_data, mem_ch, ch_level, idle
  );

  // The arbiter consumes requests and drives the RAM write port.
  modport slave (
    input  ch_valid, ch_addr, ch_data, ch_auto, ch_base, ch_load, hold,
    output ch_ready, mem_wren, mem_addr, mem_data, mem_ch, ch_level, idle
  );
endinterface

// File: rtl/dmem_wr_arbiter.sv
// Multi-channel DMEM write front-end: per-channel FIFOs, round-robin pop,
// one registered RAM write per cycle, optional auto-increment addressing.
module dmem_wr_arbiter #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  dmem_wr_arbiter_if.slave bus
);
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [LVL_W-1:0]  level      [NUM_CH];
  logic [PTR_W-1:0]  wr_ptr     [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr     [NUM_CH];
  logic [ADDR_W-1:0] cnt        [NUM_CH];
  logic [ADDR_W-1:0] push_addr  [NUM_CH];
  logic [ADDR_W-1:0] fifo_addr  [NUM_CH][FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data  [NUM_CH][FIFO_DEPTH];
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   grant;
  logic              grant_vld;

  // Ready/level/idle status derived from the registered FIFO levels.
  always_comb begin
    logic any;
    any          = 1'b0;
    bus.ch_ready = '0;
    bus.ch_level = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.ch_ready[i]                 = (level[i] < LVL_W'(FIFO_DEPTH));
      bus.ch_level[i*LVL_W +: LVL_W] = level[i];
      if (level[i] != '0) any = 1'b1;
    end
    bus.idle = !any && !bus.mem_wren;
  end

  // Push qualification and the address stored with each pushed entry.
  always_comb begin
    push = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      push[i] = bus.ch_valid[i] & bus.ch_ready[i];
      if (bus.ch_auto[i])
        push_addr[i] = bus.ch_load[i] ? bus.ch_base[i*ADDR_W +: ADDR_W] : cnt[i];
      else
        push_addr[i] = bus.ch_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Round-robin grant: first non-empty channel after the last one served.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant     = '0;
    pop       = '0;
    idx       = 0;
    if (!bus.hold) begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = (int'(last_grant) + 1 + k) % int'(NUM_CH);
        if (!grant_vld && level[CH_W'(idx)] != '0) begin
          grant_vld = 1'b1;
          grant     = CH_W'(idx);
        end
      end
    end
    if (grant_vld) pop[grant] = 1'b1;
  end

  // FIFO storage; contents need no reset since levels gate every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) begin
        fifo_addr[i][wr_ptr[i]] <= push_addr[i];
        fifo_data[i][wr_ptr[i]] <= bus.ch_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // FIFO pointers, levels and per-channel address counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        level[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        level[i] <= level[i] + LVL_W'(push[i]) - LVL_W'(pop[i]);
        if (bus.ch_load[i])
          cnt[i] <= bus.ch_base[i*ADDR_W +: ADDR_W] + ADDR_W'(push[i] & bus.ch_auto[i]);
        else if (push[i] && bus.ch_auto[i])
          cnt[i] <= cnt[i] + ADDR_W'(1);
      end
    end
  end

  // Arbitration pointer and registered RAM write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant   <= CH_W'(NUM_CH - 1);
      bus.mem_wren <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_data <= '0;
      bus.mem_ch   <= '0;
    end else begin
      bus.mem_wren <= grant_vld;
      if (grant_vld) begin
        last_grant   <= grant;
        bus.mem_addr <= fifo_addr[grant][rd_ptr[grant]];
        bus.mem_data <= fifo_data[grant][rd_ptr[grant]];
        bus.mem_ch   <= grant;
      end
    end
  end
endmodule

// File: tb/tb_dmem_wr_arbiter.sv
// Randomised and directed bench for dmem_wr_arbiter against a queue-based model.
module tb_dmem_wr_arbiter;
  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned DATA_W     = 256;
  localparam int unsigned ADDR_W     = 11;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_wr_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                       .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  dmem_wr_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                    .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: per-channel queues, counters, last served channel, expected port.
  ent_t              mq [NUM_CH][$];
  logic [ADDR_W-1:0] mcnt [NUM_CH];
  int                mlast;
  logic              e_wren;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_data;
  int                e_ch;
  logic [ADDR_W-1:0] obs_addr [$];
  int                obs_ch [$];

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      mq[i].delete();
      mcnt[i] = '0;
    end
    mlast  = NUM_CH - 1;
    e_wren = 1'b0;
    e_addr = '0;
    e_data = '0;
    e_ch   = 0;
  endtask

  task automatic compare_all();
    logic any;
    any = 1'b0;
    check("mem_wren", DATA_W'(bus.mem_wren), DATA_W'(e_wren));
    check("mem_addr", DATA_W'(bus.mem_addr), DATA_W'(e_addr));
    check("mem_data", bus.mem_data, e_data);
    check("mem_ch", DATA_W'(bus.mem_ch), DATA_W'(e_ch));
    for (int i = 0; i < NUM_CH; i++) begin
      check($sformatf("ch_level%0d", i), DATA_W'(bus.ch_level[i*LVL_W +: LVL_W]),
            DATA_W'(mq[i].size()));
      check($sformatf("ch_ready%0d", i), DATA_W'(bus.ch_ready[i]),
            DATA_W'(mq[i].size() < FIFO_DEPTH));
      if (mq[i].size() != 0) any = 1'b1;
    end
    check("idle", DATA_W'(bus.idle), DATA_W'(!any && !e_wren));
  endtask

  // Advance model by one clock using current inputs, then compare the DUT after the edge.
  task automatic step();
    int   sz [NUM_CH];
    int   g;
    int   idx;
    ent_t e;
    logic pushed;
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < NUM_CH; i++) sz[i] = mq[i].size();
    g = -1;
    if (!bus.hold)
      for (int k = 0; k < NUM_CH; k++) begin
        idx = (mlast + 1 + k) % NUM_CH;
        if (g < 0 && sz[idx] > 0) g = idx;
      end
    if (g >= 0) begin
      e      = mq[g].pop_front();
      e_wren = 1'b1;
      e_addr = e.a;
      e_data = e.d;
      e_ch   = g;
      mlast  = g;
    end else begin
      e_wren = 1'b0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      pushed = bus.ch_valid[i] && (sz[i] < FIFO_DEPTH);
      if (!bus.ch_auto[i])     a = bus.ch_addr[i*ADDR_W +: ADDR_W];
      else if (bus.ch_load[i]) a = bus.ch_base[i*ADDR_W +: ADDR_W];
      else                     a = mcnt[i];
      if (pushed) mq[i].push_back({a, bus.ch_data[i*DATA_W +: DATA_W]});
      if (bus.ch_load[i])
        mcnt[i] = bus.ch_base[i*ADDR_W +: ADDR_W] + ((pushed && bus.ch_auto[i]) ? 11'd1 : 11'd0);
      else if (pushed && bus.ch_auto[i])
        mcnt[i] = mcnt[i] + 11'd1;
    end
    @(posedge clk);
    #1;
    compare_all();
    if (bus.mem_wren) begin
      obs_addr.push_back(bus.mem_addr);
      obs_ch.push_back(int'(bus.mem_ch));
    end
  endtask

  task automatic idle_inputs();
    bus.ch_valid = '0;
    bus.ch_addr  = '0;
    bus.ch_data  = '0;
    bus.ch_auto  = '0;
    bus.ch_base  = '0;
    bus.ch_load  = '0;
    bus.hold     = 1'b0;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    obs_addr.delete();
    obs_ch.delete();
  endtask

  task automatic set_ch(input int ch, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.ch_addr[ch*ADDR_W +: ADDR_W] = a;
    bus.ch_data[ch*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    int j;
    idle_inputs();
    model_reset();
    #12;
    do_reset();

    // Single write latency.
    bus.ch_valid[0] = 1'b1;
    set_ch(0, 11'h010, {32{8'hA5}});
    step();
    bus.ch_valid = '0;
    step();
    check("single_wren", DATA_W'(bus.mem_wren), DATA_W'(1));
    check("single_addr", DATA_W'(bus.mem_addr), DATA_W'(11'h010));
    check("single_data", bus.mem_data, {32{8'hA5}});
    step();
    check("single_idle", DATA_W'(bus.idle), DATA_W'(1));

    // Reset with entries queued.
    bus.hold = 1'b1;
    bus.ch_valid = 2'b11;
    for (int k = 0; k < 2; k++) step();
    do_reset();
    check("rst_level", DATA_W'(bus.ch_level), '0);

    // Backpressure: producer on ch1 holds a word until it is accepted.
    bus.hold = 1'b1;
    j = 0;
    for (int k = 0; k < 6; k++) begin
      bus.ch_valid[1] = 1'b1;
      set_ch(1, ADDR_W'(11'h100 + j), DATA_W'(j + 1));
      if (bus.ch_ready[1]) j++;
      step();
    end
    check("bp_level", DATA_W'(bus.ch_level[LVL_W +: LVL_W]), DATA_W'(4));
    check("bp_ready", DATA_W'(bus.ch_ready[1]), DATA_W'(0));
    bus.hold = 1'b0;
    for (int k = 0; k < 20 && j < 6; k++) begin
      set_ch(1, ADDR_W'(11'h100 + j), DATA_W'(j + 1));
      if (bus.ch_ready[1]) j++;
      step();
    end
    bus.ch_valid = '0;
    for (int k = 0; k < 8; k++) step();
    check("bp_count", DATA_W'(obs_addr.size()), DATA_W'(6));
    for (int k = 0; k < obs_addr.size(); k++)
      check($sformatf("bp_order%0d", k), DATA_W'(obs_addr[k]), DATA_W'(11'h100 + k));

    // Round-robin fairness from reset.
    do_reset();
    bus.hold = 1'b1;
    bus.ch_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      set_ch(0, ADDR_W'(k), DATA_W'($urandom));
      set_ch(1, ADDR_W'(k + 32), DATA_W'($urandom));
      step();
    end
    bus.ch_valid = '0;
    bus.hold = 1'b0;
    for (int k = 0; k < 9; k++) step();
    check("rr_count", DATA_W'(obs_ch.size()), DATA_W'(8));
    for (int k = 0; k < obs_ch.size(); k++)
      check($sformatf("rr_ch%0d", k), DATA_W'(obs_ch[k]), DATA_W'(k % 2));

    // Auto-address wrap with load on the first push.
    obs_addr.delete();
    bus.ch_auto[0] = 1'b1;
    bus.ch_load[0] = 1'b1;
    bus.ch_base[ADDR_W-1:0] = 11'h7FE;
    bus.ch_valid[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_ch(0, 11'h555, DATA_W'(k));
      step();
      bus.ch_load = '0;
    end
    bus.ch_valid = '0;
    for (int k = 0; k < 4; k++) step();
    check("wrap_count", DATA_W'(obs_addr.size()), DATA_W'(4));
    if (obs_addr.size() == 4) begin
      check("wrap0", DATA_W'(obs_addr[0]), DATA_W'(11'h7FE));
      check("wrap1", DATA_W'(obs_addr[1]), DATA_W'(11'h7FF));
      check("wrap2", DATA_W'(obs_addr[2]), DATA_W'(11'h000));
      check("wrap3", DATA_W'(obs_addr[3]), DATA_W'(11'h001));
    end
    bus.ch_auto = '0;

    // Hold pulse mid-stream.
    obs_addr.delete();
    bus.hold = 1'b1;
    bus.ch_valid[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_ch(1, ADDR_W'(11'h200 + k), DATA_W'(k));
      step();
    end
    bus.ch_valid = '0;
    bus.hold = 1'b0;
    step();
    bus.hold = 1'b1;
    step();
    check("hold_gap0", DATA_W'(bus.mem_wren), DATA_W'(0));
    step();
    check("hold_gap1", DATA_W'(bus.mem_wren), DATA_W'(0));
    bus.hold = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("hold_count", DATA_W'(obs_addr.size()), DATA_W'(3));
    for (int k = 0; k < obs_addr.size(); k++)
      check($sformatf("hold_addr%0d", k), DATA_W'(obs_addr[k]), DATA_W'(11'h200 + k));

    // Random traffic with an asynchronous reset in the middle.
    for (int n = 0; n < 3000; n++) begin
      bus.ch_valid = NUM_CH'($urandom);
      bus.ch_auto  = NUM_CH'($urandom);
      bus.ch_addr  = (NUM_CH*ADDR_W)'($urandom);
      bus.ch_base  = (NUM_CH*ADDR_W)'($urandom);
      for (int i = 0; i < NUM_CH; i++) begin
        bus.ch_load[i] = ($urandom_range(0, 15) == 0);
        bus.ch_data[i*DATA_W +: DATA_W] = {$urandom, $urandom, $urandom, $urandom,
                                           $urandom, $urandom, $urandom, $urandom};
      end
      bus.hold = ($urandom_range(0, 3) == 0);
      if (n == 1500) do_reset();
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
